// File: rtl/nand4_sweep_ctrl.sv
// Steps a 4-input NAND DUV through all 16 vectors, settling each for SETTLE_CYCLES before a golden compare.
// Start at edge E0 -> o_done pulses after edge E0+16*(SETTLE_CYCLES+1); restartable, abortable, no queueing.
module nand4_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 3,
  parameter int SETTLE_W      = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_duv_f,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_d,
  output logic [3:0] o_vec_idx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [4:0] o_err_cnt,
  output logic [3:0] o_fail_vec,
  output logic       o_fail_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [SETTLE_W-1:0] CNT_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          vec_q, vec_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [4:0]          err_q, err_d;
  logic [3:0]          fvec_q, fvec_d;
  logic                fval_q, fval_d;
  logic                mismatch;

  assign mismatch = (i_duv_f != ~(&vec_q));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fval_q  <= fval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fval_d  = fval_q;

    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_d = SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fvec_d  = '0;
          fval_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (i_abort) begin
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        // An abort here drops this cycle's compare entirely.
        if (i_abort) begin
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            err_d = err_q + 5'd1;
            if (!fval_q) begin
              fvec_d = vec_q;
              fval_d = 1'b1;
            end
          end
          if (vec_q == 4'd15) begin
            state_d = DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 5'd0);
          end else begin
            state_d = SETTLE;
            vec_d   = vec_q + 4'd1;
            cnt_d   = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_a          = vec_q[3];
  assign o_b          = vec_q[2];
  assign o_c          = vec_q[1];
  assign o_d          = vec_q[0];
  assign o_vec_idx    = vec_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_cnt    = err_q;
  assign o_fail_vec   = fvec_q;
  assign o_fail_valid = fval_q;

endmodule

// File: tb/tb_nand4_sweep_ctrl.sv
// Bench for nand4_sweep_ctrl: table of DUV fault patterns, random fault masks vs a set-level model,
// and hand sequences for reset, abort and start-while-busy corners.
module tb_nand4_sweep_ctrl;

  localparam int SC    = 3;
  localparam int PERV  = SC + 1;
  localparam int SWEEP = 16 * PERV;

  logic       clk = 1'b0;
  logic       i_rst, i_start, i_abort, duv_f;
  logic       o_a, o_b, o_c, o_d, o_busy, o_done, o_pass, o_fail_valid;
  logic [3:0] o_vec_idx, o_fail_vec;
  logic [4:0] o_err_cnt;

  logic [1:0]  duv_mode;  // 0: NAND4 with per-vector flips, 1: stuck-at-1, 2: stuck-at-0
  logic [15:0] flip;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (duv_mode)
      2'd1:    duv_f = 1'b1;
      2'd2:    duv_f = 1'b0;
      default: duv_f = ~(o_a & o_b & o_c & o_d) ^ flip[{o_a, o_b, o_c, o_d}];
    endcase
  end

  nand4_sweep_ctrl #(.SETTLE_CYCLES(SC), .SETTLE_W(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_duv_f(duv_f),
    .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_d(o_d), .o_vec_idx(o_vec_idx),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_cnt(o_err_cnt),
    .o_fail_vec(o_fail_vec), .o_fail_valid(o_fail_valid)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] flip;
    int          err;
    int          fvec;
    int          fvalid;
    int          pass;
    bit          poke_start;
    bit          abort_done;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected results straight from the set of vectors on which the DUV disagrees with NAND4.
  task automatic model(input logic [15:0] m, output int err, output int fvec,
                       output int fvalid, output int pass);
    err = 0; fvec = 0; fvalid = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        if (fvalid == 0) begin
          fvec   = i;
          fvalid = 1;
        end
        err++;
      end
    end
    pass = (err == 0) ? 1 : 0;
  endtask

  task automatic sweep(input string tag, input int err, input int fvec, input int fvalid,
                       input int pass, input bit poke_start, input bit abort_done);
    int walk_bad = 0;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    for (int n = 0; n < SWEEP; n++) begin
      if (int'(o_vec_idx) != n / PERV || {o_a, o_b, o_c, o_d} != o_vec_idx || !o_busy || o_done)
        walk_bad++;
      i_start = (poke_start && n == 9 * PERV + 1) ? 1'b1 : 1'b0;
      tick;
    end
    i_start = 1'b0;
    chk({tag, " walk"}, walk_bad, 0);
    chk({tag, " done"}, int'(o_done), 1);
    chk({tag, " busy"}, int'(o_busy), 0);
    chk({tag, " vec0"}, int'({o_vec_idx, o_a, o_b, o_c, o_d}), 0);
    chk({tag, " err"}, int'(o_err_cnt), err);
    chk({tag, " fvec"}, int'(o_fail_vec), fvec);
    chk({tag, " fvalid"}, int'(o_fail_valid), fvalid);
    chk({tag, " pass"}, int'(o_pass), pass);
    i_abort = abort_done;
    tick;
    i_abort = 1'b0;
    chk({tag, " done_low"}, int'(o_done), 0);
    chk({tag, " pass_hold"}, int'(o_pass), pass);
    chk({tag, " err_hold"}, int'(o_err_cnt), err);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " vec"}, int'({o_vec_idx, o_a, o_b, o_c, o_d}), 0);
    chk({tag, " busy_done_pass"}, int'({o_busy, o_done, o_pass}), 0);
    chk({tag, " err"}, int'(o_err_cnt), 0);
    chk({tag, " fail"}, int'({o_fail_vec, o_fail_valid}), 0);
  endtask

  vec_t tbl[8];

  initial begin
    int e, fv, fvl, p, dones;
    logic [15:0] m;

    tbl[0] = '{2'd0, 16'h0000,  0,  0, 0, 1, 1'b0, 1'b0};  // golden
    tbl[1] = '{2'd1, 16'h0000,  1, 15, 1, 0, 1'b0, 1'b0};  // stuck-at-1: only 1111 wrong
    tbl[2] = '{2'd2, 16'h0000, 15,  0, 1, 0, 1'b0, 1'b0};  // stuck-at-0: 0000..1110 wrong
    tbl[3] = '{2'd0, 16'h0000,  0,  0, 0, 1, 1'b1, 1'b0};  // start pulsed at vector 9
    tbl[4] = '{2'd0, 16'h0000,  0,  0, 0, 1, 1'b0, 1'b1};  // abort during DONE
    tbl[5] = '{2'd0, 16'hFFFF, 16,  0, 1, 0, 1'b0, 1'b0};  // inverter DUV: max count
    tbl[6] = '{2'd0, 16'h0420,  2,  5, 1, 0, 1'b0, 1'b0};  // first failure kept
    tbl[7] = '{2'd0, 16'h8000,  1, 15, 1, 0, 1'b0, 1'b0};

    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; duv_mode = 2'd0; flip = '0;
    tick; tick;
    chk_reset_vals("por");
    i_rst = 1'b0;
    tick;

    for (int k = 0; k < 8; k++) begin
      duv_mode = tbl[k].mode;
      flip     = tbl[k].flip;
      sweep($sformatf("tbl%0d", k), tbl[k].err, tbl[k].fvec, tbl[k].fvalid, tbl[k].pass,
            tbl[k].poke_start, tbl[k].abort_done);
    end

    duv_mode = 2'd0;
    for (int k = 0; k < 6; k++) begin
      m = 16'($urandom);
      if (k == 0) m = m & 16'($urandom);
      flip = m;
      model(m, e, fv, fvl, p);
      sweep($sformatf("rnd%0d", k), e, fv, fvl, p, 1'b0, 1'b0);
    end

    // Reset mid-sweep at vector 6 with errors already counted.
    duv_mode = 2'd2;
    i_start = 1'b1; tick; i_start = 1'b0;
    repeat (6 * PERV) tick;
    chk("rst_mid vec", int'(o_vec_idx), 6);
    chk("rst_mid err_pre", int'(o_err_cnt), 6);
    i_rst = 1'b1;
    tick;
    chk_reset_vals("rst_mid");
    tick;
    i_rst = 1'b0;
    dones = 0;
    for (int n = 0; n < SWEEP + 8; n++) begin
      if (o_done || o_busy) dones++;
      tick;
    end
    chk("rst_mid no_done", dones, 0);

    // Abort in SETTLE of vector 5, then full restart.
    duv_mode = 2'd1;
    i_start = 1'b1; tick; i_start = 1'b0;
    repeat (5 * PERV + 1) tick;
    chk("abort_settle vec", int'(o_vec_idx), 5);
    i_abort = 1'b1; tick; i_abort = 1'b0;
    chk("abort_settle busy_done", int'({o_busy, o_done}), 0);
    chk("abort_settle vec0", int'({o_vec_idx, o_a, o_b, o_c, o_d}), 0);
    chk("abort_settle err", int'(o_err_cnt), 0);
    chk("abort_settle pass", int'(o_pass), 0);
    sweep("restart", 1, 15, 1, 0, 1'b0, 1'b0);

    // Abort in SAMPLE of vector 5: that compare is dropped, earlier results kept.
    duv_mode = 2'd2;
    i_start = 1'b1; tick; i_start = 1'b0;
    repeat (5 * PERV + SC) tick;
    i_abort = 1'b1; tick; i_abort = 1'b0;
    chk("abort_sample err", int'(o_err_cnt), 5);
    chk("abort_sample fail", int'({o_fail_vec, o_fail_valid}), 1);
    chk("abort_sample busy_pass", int'({o_busy, o_pass}), 0);
    dones = 0;
    for (int n = 0; n < SWEEP; n++) begin
      if (o_done || o_busy) dones++;
      tick;
    end
    chk("abort_sample no_done", dones, 0);

    // Start together with abort in IDLE is refused.
    i_start = 1'b1; i_abort = 1'b1; tick;
    i_start = 1'b0; i_abort = 1'b0;
    chk("start_abort busy", int'(o_busy), 0);
    tick;
    chk("start_abort busy2", int'(o_busy), 0);
    chk("start_abort err_hold", int'(o_err_cnt), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nand4_sweep_ctrl.md
Name: nand4_sweep_ctrl

Overview:
- Sweep controller for a 4-input NAND device-under-verification (DUV).
- On a start request it steps the four DUV inputs through all 16 vectors, 0000 to 1111. It holds each vector for a programmable settle time, then samples the DUV output and compares it against the golden NAND4 result.
- It reports mismatch count, the first failing vector, and pass/fail with a done pulse.
- It replaces free-running delay loops in benches and self-test wrappers with a clocked, restartable sequencer.

Parameters:
- SETTLE_CYCLES, 3: clock cycles each vector is held before sampling. Legal range 1..15.
- SETTLE_W, 4: width of the settle counter. Must hold SETTLE_CYCLES-1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start request. Sampled in IDLE only.
- i_abort  in  1  abort the running sweep.
- i_duv_f  in  1  DUV output o_f.
- o_a  out  1  DUV input a = vec_idx[3].
- o_b  out  1  DUV input b = vec_idx[2].
- o_c  out  1  DUV input c = vec_idx[1].
- o_d  out  1  DUV input d = vec_idx[0].
- o_vec_idx  out  4  current vector index.
- o_busy  out  1  high while sweeping.
- o_done  out  1  one-cycle pulse at sweep completion.
- o_pass  out  1  result of the last completed sweep.
- o_err_cnt  out  5  mismatch count, 0..16.
- o_fail_vec  out  4  first failing vector.
- o_fail_valid  out  1  o_fail_vec holds a captured failure.

Behaviour:
- All outputs are registered.
- Reset (i_rst=1 at an edge, any state) forces:
  - state IDLE;
  - o_a..o_d=0, o_vec_idx=0;
  - o_busy=0, o_done=0, o_pass=0;
  - o_err_cnt=0, o_fail_vec=0, o_fail_valid=0.
- Reset has priority over every other input.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - i_start=1 and i_abort=0 → SETTLE.
  - On that edge: vec_idx=0, o_a..o_d=0000, settle cnt=0, o_busy=1.
  - Also on that edge: clear o_err_cnt, o_fail_vec, o_fail_valid and o_pass.
  - i_start=1 together with i_abort=1 → stay in IDLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1 → SAMPLE.
  - Each vector is therefore held SETTLE_CYCLES cycles in SETTLE.
- SAMPLE (1 cycle):
  - Mismatch when i_duv_f != ~(a&b&c&d).
  - On mismatch: o_err_cnt+1. If o_fail_valid=0, capture o_fail_vec=vec_idx and set o_fail_valid=1.
  - Later mismatches never overwrite the captured vector.
  - If vec_idx==15 → DONE. Otherwise vec_idx+1, o_a..o_d updated on the same edge, cnt=0, → SETTLE.
- DONE (1 cycle):
  - o_done=1, o_busy=0.
  - o_pass=1 iff o_err_cnt==0.
  - o_a..o_d and o_vec_idx return to 0.
  - Next edge → IDLE, o_done=0.
- Latency:
  - Start accepted at edge E0 → DONE entered at edge E0+16*(SETTLE_CYCLES+1).
  - o_done is high for exactly one cycle.
- Result holding: o_pass, o_err_cnt, o_fail_vec and o_fail_valid hold until the next accepted start or reset.
- i_start while o_busy=1 is ignored. No queueing.
- i_abort=1 in SETTLE or SAMPLE:
  - next edge → IDLE, o_busy=0, no o_done pulse, o_pass=0;
  - o_a..o_d=0, o_vec_idx=0;
  - o_err_cnt, o_fail_vec and o_fail_valid keep their values.
  - Any compare in that same SAMPLE cycle is discarded.
- i_abort in DONE has no effect; completion stands.
- No wrap-around: vec_idx never increments past 15. o_err_cnt maximum is 16, and 5 bits hold it without saturation.

Test Plan:
1. Reset mid-sweep: start, SETTLE_CYCLES=3; assert i_rst for 2 cycles at vector 6. → All outputs at reset values one edge later. No o_done ever pulses.
2. Golden DUV (combinational NAND4 fed back to i_duv_f), SETTLE_CYCLES=3: start at edge E0. → o_done high exactly in the cycle after edge E0+64; o_pass=1, o_err_cnt=0, o_fail_valid=0. o_a..o_d walk 0000..1111, 4 cycles each.
3. Stuck-at-1 DUV (i_duv_f=1): full sweep. → o_err_cnt=1, o_fail_vec=4'b1111, o_fail_valid=1, o_pass=0.
4. Stuck-at-0 DUV (i_duv_f=0): full sweep. → o_err_cnt=15, o_fail_vec=4'b0000 (first failure kept), o_pass=0.
5. Abort during SETTLE of vector 5 with the stuck-at-1 DUV: → o_busy=0 next cycle, no o_done, o_err_cnt=0. A restart then runs a full 64-cycle sweep ending with o_err_cnt=1.
6. i_start pulsed at vector 9 while busy → ignored, sweep timing unchanged. i_start and i_abort together in IDLE → o_busy stays 0.
